// File: rtl/lsu_pkg.sv
// lsu_pkg -- shared types for the RV32 multicycle load/store unit.
//   lsu_size_t  : access size encoding of req_size
//   lsu_exc_t   : response exception code on resp_exc
//   lsu_state_t : control FSM states
//   size_strb() : byte-lane mask of an access placed at lane 0
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } lsu_size_t;

  typedef enum logic [1:0] {
    EXC_NONE     = 2'b00,
    EXC_MISALIGN = 2'b01,
    EXC_TIMEOUT  = 2'b10,
    EXC_ILLEGAL  = 2'b11
  } lsu_exc_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BEAT1 = 2'b01,
    ST_BEAT2 = 2'b10,
    ST_RESP  = 2'b11
  } lsu_state_t;

  function automatic logic [3:0] size_strb(input lsu_size_t sz);
    case (sz)
      SZ_BYTE: size_strb = 4'b0001;
      SZ_HALF: size_strb = 4'b0011;
      SZ_WORD: size_strb = 4'b1111;
      default: size_strb = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align -- combinational lane steering for the LSU.
// Works on a 64-bit, two-word window: the low word is the word holding the
// first byte, the high word is the next word. An access that spills into
// the high word needs a second bus beat.
// Ports:
//   off         in  byte offset addr[1:0]
//   size        in  req_size encoding
//   is_unsigned in  zero-extend loads
//   wdata       in  store data (right-aligned)
//   rdata_lo    in  load data of the first word
//   rdata_hi    in  load data of the second word
//   wdata_lanes out store data steered to its byte lanes (64-bit window)
//   wstrb_lanes out byte strobes over the 64-bit window
//   crosses     out access spills into the second word
//   misaligned  out half on odd address or word not on a 4-byte boundary
//   load_data   out shifted, merged and extended load result
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_lo,
  input  logic [31:0] rdata_hi,
  output logic [63:0] wdata_lanes,
  output logic [7:0]  wstrb_lanes,
  output logic        crosses,
  output logic        misaligned,
  output logic [31:0] load_data
);

  lsu_size_t   sz;
  logic [63:0] merged;
  logic [31:0] raw;

  always_comb begin
    sz          = lsu_size_t'(size);
    wdata_lanes = {32'h0, wdata} << {off, 3'b000};
    wstrb_lanes = {4'h0, size_strb(sz)} << off;
    crosses     = |wstrb_lanes[7:4];

    case (sz)
      SZ_HALF: misaligned = off[0];
      SZ_WORD: misaligned = |off;
      default: misaligned = 1'b0;
    endcase

    // Merge both words first, then shift, so split loads extend correctly.
    merged = {rdata_hi, rdata_lo} >> {off, 3'b000};
    raw    = merged[31:0];

    case (sz)
      SZ_BYTE: load_data = {{24{~is_unsigned & raw[7]}}, raw[7:0]};
      SZ_HALF: load_data = {{16{~is_unsigned & raw[15]}}, raw[15:0]};
      default: load_data = raw;
    endcase
  end

endmodule

// File: rtl/rv32_lsu_multicycle.sv
// rv32_lsu_multicycle -- multicycle RV32 load/store unit on a simple
// valid/ready word bus.
// Build option: define LSU_MISALIGNED_SPLIT_EN to execute misaligned
// accesses (split into two beats when they cross a word); otherwise they
// are answered with a misaligned exception and no bus traffic.
// Parameters: ADDR_W byte-address width, TIMEOUT_CYCLES max wait per beat
//             (0 = wait forever).
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready            request handshake (ready only in IDLE)
//   req_write, req_size,           store flag, size, zero-extend flag,
//   req_unsigned, req_addr,        byte address, store data
//   req_wdata
//   resp_valid, resp_rdata,        one-cycle completion pulse with load
//   resp_exc                       data and exception code
//   bus_valid/bus_ready            per-beat handshake
//   bus_addr, bus_we, bus_wstrb,   word-aligned beat address and write
//   bus_wdata, bus_rdata           controls, write and read data
module rv32_lsu_multicycle
  import lsu_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic [1:0]        resp_exc,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_we,
  output logic [3:0]        bus_wstrb,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata
);

`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  localparam int TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t        state_q, state_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              split_q, split_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [31:0]       lo_q, lo_d;
  logic [31:0]       rdata_q, rdata_d;
  lsu_exc_t          exc_q, exc_d;

  // Alignment unit looks at the incoming request while idle (to classify
  // it) and at the registered request during beats.
  logic              in_idle;
  logic              beat_hi;
  logic [1:0]        al_off, al_size;
  logic [63:0]       wdata_lanes;
  logic [7:0]        wstrb_lanes;
  logic              crosses, misaligned;
  logic [31:0]       load_data;
  logic [ADDR_W-1:0] base_addr;

  assign in_idle = (state_q == ST_IDLE);
  assign beat_hi = (state_q == ST_BEAT2);
  assign al_off  = in_idle ? req_addr[1:0] : addr_q[1:0];
  assign al_size = in_idle ? req_size : size_q;

  lsu_align u_align (
    .off         (al_off),
    .size        (al_size),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .rdata_lo    (beat_hi ? lo_q : bus_rdata),
    .rdata_hi    (bus_rdata),
    .wdata_lanes (wdata_lanes),
    .wstrb_lanes (wstrb_lanes),
    .crosses     (crosses),
    .misaligned  (misaligned),
    .load_data   (load_data)
  );

  // All bus outputs derive from registered state, so they hold steady
  // for the whole beat regardless of how long bus_ready stays low.
  assign base_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus_valid  = (state_q == ST_BEAT1) || beat_hi;
  assign bus_addr   = beat_hi ? base_addr + ADDR_W'(4) : base_addr;
  assign bus_we     = bus_valid & write_q;
  assign bus_wstrb  = bus_we ? (beat_hi ? wstrb_lanes[7:4] : wstrb_lanes[3:0]) : 4'h0;
  assign bus_wdata  = bus_we ? (beat_hi ? wdata_lanes[63:32] : wdata_lanes[31:0]) : 32'h0;

  assign req_ready  = in_idle;
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_exc   = exc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      split_q <= 1'b0;
      tmo_q   <= '0;
      lo_q    <= 32'h0;
      rdata_q <= 32'h0;
      exc_q   <= EXC_NONE;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      split_q <= split_d;
      tmo_q   <= tmo_d;
      lo_q    <= lo_d;
      rdata_q <= rdata_d;
      exc_q   <= exc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    split_d = split_q;
    tmo_d   = tmo_q;
    lo_d    = lo_q;
    rdata_d = rdata_q;
    exc_d   = exc_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          tmo_d   = '0;
          split_d = SPLIT_EN & crosses;
          rdata_d = 32'h0;
          exc_d   = EXC_NONE;
          if (lsu_size_t'(req_size) == SZ_ILL) begin
            exc_d   = EXC_ILLEGAL;
            split_d = 1'b0;
            state_d = ST_RESP;
          end else if (misaligned && !SPLIT_EN) begin
            exc_d   = EXC_MISALIGN;
            state_d = ST_RESP;
          end else begin
            state_d = ST_BEAT1;
          end
        end
      end

      ST_BEAT1, ST_BEAT2: begin
        if (bus_ready) begin
          tmo_d = '0;
          if (!beat_hi && split_q) begin
            lo_d    = bus_rdata;
            state_d = ST_BEAT2;
          end else begin
            rdata_d = write_q ? 32'h0 : load_data;
            exc_d   = EXC_NONE;
            state_d = ST_RESP;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LAST)) begin
          // A first beat that already completed is not undone here.
          tmo_d   = '0;
          rdata_d = 32'h0;
          exc_d   = EXC_TIMEOUT;
          state_d = ST_RESP;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      ST_RESP: begin
        split_d = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rv32_lsu_multicycle.sv
// Directed testbench for rv32_lsu_multicycle (TIMEOUT_CYCLES = 4).
// Expectations for misaligned accesses follow LSU_MISALIGNED_SPLIT_EN.
module tb_rv32_lsu_multicycle;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_exc;
  logic        bus_valid;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = 32'h0;

  always #5 clk = ~clk;

  rv32_lsu_multicycle #(
    .ADDR_W         (32),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_exc     (resp_exc),
    .bus_valid    (bus_valid),
    .bus_ready    (bus_ready),
    .bus_addr     (bus_addr),
    .bus_we       (bus_we),
    .bus_wstrb    (bus_wstrb),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  // Results of the last transaction
  int          r_lat;
  int          r_beats;
  int          r_bv;
  logic        r_stable;
  logic [31:0] r_addr  [2];
  logic [3:0]  r_strb  [2];
  logic [31:0] r_wdata [2];
  logic        r_we    [2];
  logic [31:0] r_rdata;
  logic [1:0]  r_exc;

  // Issues one request and plays the bus: beat n returns rd0/rd1, and
  // bus_ready is driven with rdy while bus_valid is high.
  task automatic run_req(input string name, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd0, input logic [31:0] rd1, input logic rdy);
    int          beat_n;
    logic        seen;
    logic [31:0] first_addr;
    r_lat = -1; r_beats = 0; r_bv = 0; r_stable = 1'b1;
    r_rdata = 32'hDEAD_BEEF; r_exc = 2'bxx;
    for (int i = 0; i < 2; i++) begin
      r_addr[i] = 32'hxxxx_xxxx; r_strb[i] = 4'hx; r_wdata[i] = 32'hx; r_we[i] = 1'bx;
    end
    check({name, ".req_ready"}, req_ready, 1);
    req_write = wr; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    beat_n = 0; seen = 1'b0; first_addr = 32'h0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (resp_valid) begin
        r_lat = cyc; r_rdata = resp_rdata; r_exc = resp_exc;
        break;
      end
      if (bus_valid) begin
        r_bv++;
        if (!seen) begin
          first_addr = bus_addr; seen = 1'b1;
        end else if (bus_addr !== first_addr) begin
          r_stable = 1'b0;
        end
        bus_ready = rdy;
        bus_rdata = (beat_n == 0) ? rd0 : rd1;
        if (rdy) begin
          if (beat_n < 2) begin
            r_addr[beat_n] = bus_addr; r_strb[beat_n] = bus_wstrb;
            r_wdata[beat_n] = bus_wdata; r_we[beat_n] = bus_we;
          end
          beat_n++;
          seen = 1'b0;
        end
      end else begin
        bus_ready = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus_ready = 1'b0;
    r_beats = beat_n;
    $display("txn %s addr=0x%08h size=%0d wr=%0d lat=%0d beats=%0d rdata=0x%08h exc=%0d",
             name, addr, sz, wr, r_lat, r_beats, r_rdata, r_exc);
    if (r_lat > 0) begin
      @(posedge clk); #1;
      check({name, ".pulse"}, resp_valid, 0);
      check({name, ".idle"}, req_ready, 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_resp;
    repeat (3) @(posedge clk);
    #1;
    check("rst.req_ready", req_ready, 1);
    check("rst.resp_valid", resp_valid, 0);
    check("rst.resp_exc", resp_exc, 0);
    check("rst.resp_rdata", resp_rdata, 0);
    check("rst.bus_valid", bus_valid, 0);
    check("rst.bus_we", bus_we, 0);
    check("rst.bus_wstrb", bus_wstrb, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Signed byte load from lane 3
    run_req("lb_103", 0, 2'b00, 0, 32'h103, 32'h0, 32'h80AABBCC, 32'h0, 1);
    check("lb_103.lat", r_lat, 2);
    check("lb_103.beats", r_beats, 1);
    check("lb_103.addr", r_addr[0], 32'h100);
    check("lb_103.we", r_we[0], 0);
    check("lb_103.rdata", r_rdata, 32'hFFFFFF80);
    check("lb_103.exc", r_exc, 0);

    run_req("lbu_103", 0, 2'b00, 1, 32'h103, 32'h0, 32'h80AABBCC, 32'h0, 1);
    check("lbu_103.rdata", r_rdata, 32'h00000080);

    run_req("lh_100", 0, 2'b01, 0, 32'h100, 32'h0, 32'h80AABBCC, 32'h0, 1);
    check("lh_100.rdata", r_rdata, 32'hFFFFBBCC);

    run_req("lhu_102", 0, 2'b01, 1, 32'h102, 32'h0, 32'h80AABBCC, 32'h0, 1);
    check("lhu_102.rdata", r_rdata, 32'h000080AA);

    run_req("lw_104", 0, 2'b10, 0, 32'h104, 32'h0, 32'h12345678, 32'h0, 1);
    check("lw_104.addr", r_addr[0], 32'h104);
    check("lw_104.rdata", r_rdata, 32'h12345678);

    // Half store into the upper lanes
    run_req("sh_202", 1, 2'b01, 0, 32'h202, 32'h0000BEEF, 32'h0, 32'h0, 1);
    check("sh_202.addr", r_addr[0], 32'h200);
    check("sh_202.we", r_we[0], 1);
    check("sh_202.wstrb", r_strb[0], 4'b1100);
    check("sh_202.wdata", r_wdata[0][31:16], 16'hBEEF);
    check("sh_202.rdata", r_rdata, 0);
    check("sh_202.exc", r_exc, 0);

    run_req("sb_101", 1, 2'b00, 0, 32'h101, 32'h0000005A, 32'h0, 32'h0, 1);
    check("sb_101.wstrb", r_strb[0], 4'b0010);
    check("sb_101.wdata", r_wdata[0][15:8], 8'h5A);

    // Word-crossing misaligned load
    run_req("lw_301", 0, 2'b10, 0, 32'h301, 32'h0, 32'h11223344, 32'h55667788, 1);
`ifdef LSU_MISALIGNED_SPLIT_EN
    check("lw_301.beats", r_beats, 2);
    check("lw_301.addr0", r_addr[0], 32'h300);
    check("lw_301.addr1", r_addr[1], 32'h304);
    check("lw_301.rdata", r_rdata, 32'h88112233);
    check("lw_301.exc", r_exc, 0);
    check("lw_301.lat", r_lat, 3);
`else
    check("lw_301.bus_valid", r_bv, 0);
    check("lw_301.exc", r_exc, 1);
    check("lw_301.rdata", r_rdata, 0);
    check("lw_301.lat", r_lat, 1);
`endif

    // Misaligned half that fits in one word
    run_req("lh_101", 0, 2'b01, 0, 32'h101, 32'h0, 32'h80AABBCC, 32'h0, 1);
`ifdef LSU_MISALIGNED_SPLIT_EN
    check("lh_101.beats", r_beats, 1);
    check("lh_101.addr", r_addr[0], 32'h100);
    check("lh_101.rdata", r_rdata, 32'hFFFFAABB);
`else
    check("lh_101.bus_valid", r_bv, 0);
    check("lh_101.exc", r_exc, 1);
`endif

    // Bus never answers
    run_req("tmo_400", 0, 2'b10, 0, 32'h400, 32'h0, 32'h12345678, 32'h0, 0);
    check("tmo_400.bv_cycles", r_bv, TMO);
    check("tmo_400.stable", r_stable, 1);
    check("tmo_400.exc", r_exc, 2);
    check("tmo_400.rdata", r_rdata, 0);
    check("tmo_400.lat", r_lat, TMO + 1);

    // Illegal size
    run_req("ill_600", 0, 2'b11, 0, 32'h600, 32'h0, 32'h12345678, 32'h0, 1);
    check("ill_600.bus_valid", r_bv, 0);
    check("ill_600.exc", r_exc, 3);
    check("ill_600.rdata", r_rdata, 0);
    check("ill_600.lat", r_lat, 1);

    // Address wrap on the second beat
    run_req("lw_wrap", 0, 2'b10, 0, 32'hFFFFFFFE, 32'h0, 32'hAABBCCDD, 32'h11223344, 1);
`ifdef LSU_MISALIGNED_SPLIT_EN
    check("lw_wrap.beats", r_beats, 2);
    check("lw_wrap.addr0", r_addr[0], 32'hFFFFFFFC);
    check("lw_wrap.addr1", r_addr[1], 32'h00000000);
    check("lw_wrap.rdata", r_rdata, 32'h3344AABB);
`else
    check("lw_wrap.bus_valid", r_bv, 0);
    check("lw_wrap.exc", r_exc, 1);
`endif

    // Reset in the middle of a beat
    req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h500;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    bus_ready = 1'b0;
    check("rstmid.bus_valid", bus_valid, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstmid.req_ready", req_ready, 1);
    check("rstmid.bus_valid_off", bus_valid, 0);
    seen_resp = resp_valid;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (resp_valid) seen_resp = 1'b1;
    end
    check("rstmid.no_resp", seen_resp, 0);
    $display("txn rstmid addr=0x00000500 aborted");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rv32_lsu_multicycle.md
RV32_LSU_MULTICYCLE -- requirements
Module: rv32_lsu_multicycle

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning byte-address width of the request and bus addresses.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum bus wait in cycles per beat; 0 disables the timeout.
REQ-003 SHALL have ports: clk in 1 clock; rst in 1, synchronous, active-high reset.
REQ-004 SHALL have ports: req_valid in 1 request strobe; req_ready out 1 request accepted; req_write in 1 (1=store).
REQ-005 SHALL have ports: req_size in 2 (00 byte, 01 half, 10 word, 11 illegal); req_unsigned in 1 zero-extend loads; req_addr in ADDR_W; req_wdata in 32.
REQ-006 SHALL have ports: resp_valid out 1 one-cycle completion pulse; resp_rdata out 32 extended load data; resp_exc out 2 (00 none, 01 misaligned, 10 timeout, 11 illegal size).
REQ-007 SHALL have ports: bus_valid out 1; bus_ready in 1; bus_addr out ADDR_W word-aligned; bus_we out 1; bus_wstrb out 4; bus_wdata out 32; bus_rdata in 32.

Function
REQ-008 SHALL implement states IDLE, BEAT1, BEAT2, RESP; IDLE->BEAT1 on accept, BEAT1->BEAT2 if split, else ->RESP; BEAT2->RESP; RESP->IDLE.
REQ-009 SHALL drive req_ready=1 only in IDLE; a request is accepted on req_valid&&req_ready and its fields are registered.
REQ-010 SHALL hold bus_valid and all bus_* outputs stable from the beat start until the cycle bus_ready=1; the beat completes in that cycle.
REQ-011 SHALL assert resp_valid for exactly one cycle (in RESP), the cycle after the final beat completes; minimum latency accept->resp_valid is 2 cycles with bus_ready tied high.
REQ-012 SHALL, for an illegal size, perform no bus beat and go IDLE->RESP with resp_exc=11 and resp_rdata=0.
REQ-013 SHALL define misaligned as: half with addr[0]=1, word with addr[1:0]!=0.
REQ-014 SHALL place store bytes on lanes addr[1:0] upward, with bus_wstrb set for exactly those lanes.
REQ-015 SHALL shift load bytes down from lane addr[1:0], then sign-extend (req_unsigned=0) or zero-extend (req_unsigned=1); resp_rdata for stores is 0.
REQ-016 SHALL, on a TIMEOUT_CYCLES-cycle wait without bus_ready, drop bus_valid, go to RESP with resp_exc=10 and resp_rdata=0.
REQ-017 SHALL not roll back a completed BEAT1 store when BEAT2 times out.
REQ-018 SHALL compute the BEAT2 address as the BEAT1 address +4, modulo 2^ADDR_W.

Reset
REQ-019 SHALL, on rst, enter IDLE, drive req_ready=1, and clear resp_valid, resp_exc, resp_rdata, bus_valid, bus_we, bus_wstrb, the timeout counter and the split flag; rst mid-beat SHALL abort the beat with no response.

Configuration
REQ-020 SHALL make misaligned support selectable with macro LSU_MISALIGNED_SPLIT_EN.
REQ-021 SHALL, without LSU_MISALIGNED_SPLIT_EN, answer a misaligned request with no bus beat, IDLE->RESP, resp_exc=01, resp_rdata=0.
REQ-022 SHALL, with LSU_MISALIGNED_SPLIT_EN, execute a misaligned access fitting one word as one beat, and a word-crossing access as BEAT1 (low bytes, addr&~3) plus BEAT2 (high bytes, lane 0 upward), merging load bytes before extension, with resp_exc=00.

Structure
REQ-023 SHALL declare lsu_size_t, lsu_exc_t and the state enum in shared package lsu_pkg.
REQ-024 SHALL place lane shifting, strobe generation and sign/zero extension in combinational sub-module lsu_align.

Verification
REQ-025 SHALL verify: signed byte load at 0x103 with bus_rdata=0x80AABBCC, bus_ready=1 -> bus_addr=0x100, resp_rdata=0xFFFFFF80, resp_exc=00, resp_valid 2 cycles after accept.
REQ-026 SHALL verify: half store 0xBEEF at 0x202 -> bus_addr=0x200, bus_wstrb=1100, bus_wdata[31:16]=0xBEEF.
REQ-027 SHALL verify: word load at 0x301, macro off -> no bus_valid, resp_exc=01; macro on with beats 0x11223344 then 0x55667788 -> beats at 0x300/0x304, resp_rdata=0x88112233.
REQ-028 SHALL verify: bus_ready held 0, TIMEOUT_CYCLES=4 -> bus_valid drops after 4 cycles, resp_exc=10, resp_rdata=0.
REQ-029 SHALL verify: req_size=11 -> resp_exc=11 with no beat; word load at 0xFFFFFFFE, macro on -> BEAT2 at 0x00000000; rst mid-beat -> no resp_valid, req_ready=1 next cycle.
